// File: rtl/if_id_stage_pkg.sv
// Shared constants for the IF/ID register: extender select codes, RV32I opcodes and the NOP word.
package if_id_stage_pkg;

    localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
    localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
    localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
    localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
    localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;
    localparam logic [5:0] EXT_CTRL_NONE        = 6'b000000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_ENC = 32'h00000013;

    // SLLI (001) and SRLI/SRAI (101) carry a shift amount instead of a 12-bit immediate
    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch/hazard-side inputs and ID-side outputs of the IF/ID register.
interface if_id_stage_if;
    logic        stall;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [4:0]  iimm_shamt;
    logic [11:0] iimm;
    logic [11:0] simm;
    logic [11:0] bimm;
    logic [19:0] uimm;
    logic [19:0] jimm;
    logic [5:0]  EXTOp;

    modport master (
        output stall, flush, if_valid, if_pc, if_instr,
        input  id_valid, id_pc, id_instr, iimm_shamt, iimm, simm, bimm, uimm, jimm, EXTOp
    );

    modport slave (
        input  stall, flush, if_valid, if_pc, if_instr,
        output id_valid, id_pc, id_instr, iimm_shamt, iimm, simm, bimm, uimm, jimm, EXTOp
    );
endinterface

// File: rtl/if_id_stage_imm_sel_decode.sv
// Maps opcode/funct3 of a valid instruction to the one-hot immediate extender select.
module imm_sel_decode
    import if_id_stage_pkg::*;
(
    input  logic       valid,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic [5:0] ext_op
);

    always_comb begin
        ext_op = EXT_CTRL_NONE;
        if (valid) begin
            case (opcode)
                OPC_LUI, OPC_AUIPC: ext_op = EXT_CTRL_UTYPE;
                OPC_JAL:            ext_op = EXT_CTRL_JTYPE;
                OPC_JALR, OPC_LOAD: ext_op = EXT_CTRL_ITYPE;
                OPC_OPIMM:          ext_op = is_shift_funct3(funct3) ? EXT_CTRL_ITYPE_SHAMT
                                                                     : EXT_CTRL_ITYPE;
                OPC_STORE:          ext_op = EXT_CTRL_STYPE;
                OPC_BRANCH:         ext_op = EXT_CTRL_BTYPE;
                default:            ext_op = EXT_CTRL_NONE;
            endcase
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall/flush, plus combinational immediate slicing and EXTOp decode.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_ENC,
    parameter logic [31:0] PC_RESET  = 32'h00000000
) (
    input  logic         clk,
    input  logic         rst,
    if_id_stage_if.slave bus
);

    logic        vld_p1;
    logic [31:0] pc_p1;
    logic [31:0] instr_p1;
    logic [5:0]  ext_op;

    // IF -> ID boundary: a flush kills the held instruction even during a stall
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            vld_p1   <= 1'b0;
            pc_p1    <= PC_RESET;
            instr_p1 <= NOP_INSTR;
        end else if (!bus.stall) begin
            vld_p1   <= bus.if_valid;
            pc_p1    <= bus.if_pc;
            instr_p1 <= bus.if_instr;
        end
    end

    imm_sel_decode u_imm_sel_decode (
        .valid  (vld_p1),
        .opcode (instr_p1[6:0]),
        .funct3 (instr_p1[14:12]),
        .ext_op (ext_op)
    );

    assign bus.id_valid   = vld_p1;
    assign bus.id_pc      = pc_p1;
    assign bus.id_instr   = instr_p1;
    assign bus.iimm_shamt = instr_p1[24:20];
    assign bus.iimm       = instr_p1[31:20];
    assign bus.simm       = {instr_p1[31:25], instr_p1[11:7]};
    assign bus.bimm       = {instr_p1[31], instr_p1[7], instr_p1[30:25], instr_p1[11:8]};
    assign bus.uimm       = instr_p1[31:12];
    assign bus.jimm       = {instr_p1[31], instr_p1[19:12], instr_p1[20], instr_p1[30:21]};
    assign bus.EXTOp      = ext_op;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, immediate slicing, EXTOp decode, stall, flush and mid-stream reset.
module tb_if_id_stage;
    import if_id_stage_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    if_id_stage_if bus ();

    if_id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_instr = instr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h0000_1234, 32'hFFF00093);
        tick();
        tick();
        vectors++;
        if (bus.id_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.id_valid);
        end
        vectors++;
        if (bus.id_pc !== 32'h0) begin
            miscompares++; $display("FAIL reset_pc: got %h expected 00000000", bus.id_pc);
        end
        vectors++;
        if (bus.id_instr !== 32'h00000013) begin
            miscompares++; $display("FAIL reset_instr: got %h expected 00000013", bus.id_instr);
        end
        vectors++;
        if (bus.EXTOp !== 6'b000000) begin
            miscompares++; $display("FAIL reset_extop: got %b expected 000000", bus.EXTOp);
        end
        rst = 1'b0;
    endtask

    task automatic test_itype();
        drive(1'b1, 32'h00000040, 32'hFFF00093);
        tick();
        vectors++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h40) begin
            miscompares++;
            $display("FAIL itype_load: got valid=%b pc=%h expected valid=1 pc=00000040", bus.id_valid, bus.id_pc);
        end
        vectors++;
        if (bus.iimm !== 12'hFFF) begin
            miscompares++; $display("FAIL itype_iimm: got %h expected fff", bus.iimm);
        end
        vectors++;
        if (bus.EXTOp !== 6'b010000) begin
            miscompares++; $display("FAIL itype_extop: got %b expected 010000", bus.EXTOp);
        end
    endtask

    task automatic test_shift_store();
        drive(1'b1, 32'h00000044, 32'h00509093);
        tick();
        vectors++;
        if (bus.iimm_shamt !== 5'd5) begin
            miscompares++; $display("FAIL slli_shamt: got %0d expected 5", bus.iimm_shamt);
        end
        vectors++;
        if (bus.EXTOp !== 6'b100000) begin
            miscompares++; $display("FAIL slli_extop: got %b expected 100000", bus.EXTOp);
        end
        drive(1'b1, 32'h00000048, 32'h00112623);
        tick();
        vectors++;
        if (bus.simm !== 12'h00C) begin
            miscompares++; $display("FAIL sw_simm: got %h expected 00c", bus.simm);
        end
        vectors++;
        if (bus.EXTOp !== 6'b001000) begin
            miscompares++; $display("FAIL sw_extop: got %b expected 001000", bus.EXTOp);
        end
    endtask

    task automatic test_branch_upper();
        drive(1'b1, 32'h0000004C, 32'hFE000EE3);
        tick();
        vectors++;
        if (bus.bimm !== 12'hFFE) begin
            miscompares++; $display("FAIL beq_bimm: got %h expected ffe", bus.bimm);
        end
        vectors++;
        if (bus.EXTOp !== 6'b000100) begin
            miscompares++; $display("FAIL beq_extop: got %b expected 000100", bus.EXTOp);
        end
        drive(1'b1, 32'h00000050, 32'h123450B7);
        tick();
        vectors++;
        if (bus.uimm !== 20'h12345) begin
            miscompares++; $display("FAIL lui_uimm: got %h expected 12345", bus.uimm);
        end
        vectors++;
        if (bus.EXTOp !== 6'b000010) begin
            miscompares++; $display("FAIL lui_extop: got %b expected 000010", bus.EXTOp);
        end
    endtask

    task automatic test_stall_jal();
        // jal x0, 8 -> jimm = 20'h00004 (offset/2)
        drive(1'b1, 32'h00000054, 32'h0080006F);
        tick();
        vectors++;
        if (bus.jimm !== 20'h00004 || bus.EXTOp !== 6'b000001) begin
            miscompares++;
            $display("FAIL jal_load: got jimm=%h extop=%b expected jimm=00004 extop=000001", bus.jimm, bus.EXTOp);
        end
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00000100 + 32'(i * 4), 32'h00112623 + 32'(i << 20));
            tick();
            vectors++;
            if (bus.id_instr !== 32'h0080006F || bus.id_pc !== 32'h54 ||
                bus.EXTOp !== 6'b000001 || bus.id_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got instr=%h pc=%h extop=%b valid=%b expected instr=0080006f pc=00000054 extop=000001 valid=1",
                         i, bus.id_instr, bus.id_pc, bus.EXTOp, bus.id_valid);
            end
        end
        bus.stall = 1'b0;
        drive(1'b1, 32'h00000058, 32'h00112623);
        tick();
        vectors++;
        if (bus.id_instr !== 32'h00112623 || bus.id_pc !== 32'h58 || bus.EXTOp !== 6'b001000) begin
            miscompares++;
            $display("FAIL stall_release: got instr=%h pc=%h extop=%b expected instr=00112623 pc=00000058 extop=001000",
                     bus.id_instr, bus.id_pc, bus.EXTOp);
        end
    endtask

    task automatic test_flush_stall();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        drive(1'b1, 32'h0000005C, 32'h123450B7);
        tick();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        vectors++;
        if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h00000013 ||
            bus.id_pc !== 32'h0 || bus.EXTOp !== 6'b000000) begin
            miscompares++;
            $display("FAIL flush_stall: got valid=%b instr=%h pc=%h extop=%b expected valid=0 instr=00000013 pc=00000000 extop=000000",
                     bus.id_valid, bus.id_instr, bus.id_pc, bus.EXTOp);
        end
    endtask

    task automatic test_other_opcodes();
        logic [31:0] instrs [8];
        logic [5:0]  exps   [8];
        instrs[0] = 32'h000080E7; exps[0] = 6'b010000; // jalr
        instrs[1] = 32'h0040A103; exps[1] = 6'b010000; // lw
        instrs[2] = 32'h00001097; exps[2] = 6'b000010; // auipc
        instrs[3] = 32'h4010D093; exps[3] = 6'b100000; // srai
        instrs[4] = 32'h0FF0F093; exps[4] = 6'b010000; // andi
        instrs[5] = 32'h00000073; exps[5] = 6'b000000; // ecall
        instrs[6] = 32'h0000000F; exps[6] = 6'b000000; // fence
        instrs[7] = 32'h002081B3; exps[7] = 6'b000000; // add
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h00000200 + 32'(i * 4), instrs[i]);
            tick();
            vectors++;
            if (bus.EXTOp !== exps[i] || bus.id_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL opcode_decode[%0d]: instr=%h got extop=%b valid=%b expected extop=%b valid=1",
                         i, instrs[i], bus.EXTOp, bus.id_valid, exps[i]);
            end
        end
        vectors++;
        if (bus.id_pc !== 32'h0000021C) begin
            miscompares++; $display("FAIL opcode_pc: got %h expected 0000021c", bus.id_pc);
        end
    endtask

    task automatic test_invalid_fetch();
        drive(1'b0, 32'h00000300, 32'hFFF00093);
        tick();
        vectors++;
        if (bus.id_valid !== 1'b0 || bus.EXTOp !== 6'b000000) begin
            miscompares++;
            $display("FAIL invalid_fetch: got valid=%b extop=%b expected valid=0 extop=000000", bus.id_valid, bus.EXTOp);
        end
        vectors++;
        if (bus.id_instr !== 32'hFFF00093 || bus.id_pc !== 32'h300) begin
            miscompares++;
            $display("FAIL invalid_fetch_data: got instr=%h pc=%h expected instr=fff00093 pc=00000300", bus.id_instr, bus.id_pc);
        end
    endtask

    task automatic test_flush_only();
        drive(1'b1, 32'h00000310, 32'h0080006F);
        tick();
        bus.flush = 1'b1;
        drive(1'b1, 32'h00000314, 32'h00112623);
        tick();
        bus.flush = 1'b0;
        vectors++;
        if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h00000013 || bus.id_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_only: got valid=%b instr=%h pc=%h expected valid=0 instr=00000013 pc=00000000",
                     bus.id_valid, bus.id_instr, bus.id_pc);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 32'h00000400, 32'h123450B7);
        tick();
        rst       = 1'b1;
        bus.stall = 1'b1;
        drive(1'b1, 32'h00000404, 32'h00509093);
        tick();
        rst       = 1'b0;
        bus.stall = 1'b0;
        vectors++;
        if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h00000013 ||
            bus.id_pc !== 32'h0 || bus.EXTOp !== 6'b000000 || bus.uimm !== 20'h00000) begin
            miscompares++;
            $display("FAIL reset_midstream: got valid=%b instr=%h pc=%h extop=%b uimm=%h expected valid=0 instr=00000013 pc=00000000 extop=000000 uimm=00000",
                     bus.id_valid, bus.id_instr, bus.id_pc, bus.EXTOp, bus.uimm);
        end
        drive(1'b1, 32'h00000408, 32'hFE000EE3);
        tick();
        vectors++;
        if (bus.id_valid !== 1'b1 || bus.EXTOp !== 6'b000100 || bus.id_pc !== 32'h408) begin
            miscompares++;
            $display("FAIL after_reset_load: got valid=%b extop=%b pc=%h expected valid=1 extop=000100 pc=00000408",
                     bus.id_valid, bus.EXTOp, bus.id_pc);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        test_reset();
        test_itype();
        test_shift_store();
        test_branch_upper();
        test_stall_jal();
        test_flush_stall();
        test_other_opcodes();
        test_invalid_fetch();
        test_flush_only();
        test_reset_midstream();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register of the 5-stage RV32I pipeline. It captures the fetched PC and instruction, then applies stall (hold) and flush (bubble) control.
- From the registered instruction it slices the immediate fields and decodes the one-hot EXTOp that the immediate extender in ID consumes directly.
- Sits between instruction fetch and the ID-stage immediate extender/control unit.

Parameters:
- NOP_INSTR, 32'h00000013, instruction word loaded on reset and flush (addi x0,x0,0).
- PC_RESET, 32'h00000000, id_pc value on reset and flush.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hazard unit: hold current ID contents
- flush  input  1  branch/jump redirect: replace ID contents with a bubble
- if_valid  input  1  fetch presents a valid instruction
- if_pc  input  32  PC of the fetched instruction
- if_instr  input  32  fetched instruction word
- id_valid  output  1  ID stage holds a real instruction
- id_pc  output  32  registered PC
- id_instr  output  32  registered instruction
- iimm_shamt  output  5  id_instr[24:20]
- iimm  output  12  id_instr[31:20]
- simm  output  12  {id_instr[31:25], id_instr[11:7]}
- bimm  output  12  {id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8]}
- uimm  output  20  id_instr[31:12]
- jimm  output  20  {id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21]}
- EXTOp  output  6  one-hot extender select

Behaviour:
- Reset is synchronous, active-high, and sampled at the rising edge of clk. While rst is high at an edge:
  - id_valid = 0
  - id_pc = PC_RESET
  - id_instr = NOP_INSTR
  - Derived outputs follow from those values; EXTOp = 0.
- Register update priority at each edge is rst > flush > stall > load.
  - flush: same values as reset. Flush wins over a simultaneous stall, because a redirect kills the held instruction.
  - stall (no flush): id_valid, id_pc and id_instr all hold.
  - load: id_valid <= if_valid, id_pc <= if_pc, id_instr <= if_instr. When if_valid = 0, the instruction and PC are still loaded and only id_valid is 0.
- Latency: 1 cycle from fetch inputs to the id_* outputs.
- Immediate fields and EXTOp are purely combinational from id_instr and id_valid. They add no extra register stage.
- EXTOp is 0 whenever id_valid = 0. Otherwise it is decoded from opcode id_instr[6:0] and funct3 id_instr[14:12]:
  - 0110111 (LUI), 0010111 (AUIPC) -> 6'b000010 UTYPE
  - 1101111 (JAL) -> 6'b000001 JTYPE
  - 1100111 (JALR), 0000011 (loads) -> 6'b010000 ITYPE
  - 0010011 with funct3 001 or 101 (SLLI/SRLI/SRAI) -> 6'b100000 ITYPE_SHAMT
  - 0010011 with any other funct3 -> 6'b010000 ITYPE
  - 0100011 (stores) -> 6'b001000 STYPE
  - 1100011 (branches) -> 6'b000100 BTYPE
  - All other opcodes (R-type, FENCE, SYSTEM, illegal) -> 6'b000000
- EXTOp is always one-hot or zero; it never has two bits set.
- Stall lasting N cycles: outputs stay constant for N cycles. The instruction on if_* during those cycles is not captured; fetch re-presents it.
- Reset asserted mid-stall: reset wins and the pipeline restarts from a bubble.

Decomposition:
- Shared package holds:
  - EXT_CTRL_* one-hot codes (ITYPE_SHAMT, ITYPE, STYPE, BTYPE, UTYPE, JTYPE)
  - Opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH)
  - The NOP encoding
- One sub-module, imm_sel_decode: combinational mapping from opcode/funct3/valid to EXTOp. It is reused by the verification scoreboard.

Test Plan:
- Reset, then load if_instr = 32'hFFF00093 (addi x1,x0,-1), if_pc = 32'h00000040, if_valid = 1 -> next cycle: id_valid = 1, id_pc = 32'h40, iimm = 12'hFFF, EXTOp = 6'b010000.
- Load 32'h00509093 (slli x1,x1,5) -> iimm_shamt = 5'd5, EXTOp = 6'b100000. Then load 32'h00112623 (sw x1,12(x2)) -> simm = 12'h00C, EXTOp = 6'b001000.
- Load 32'hFE000EE3 (beq x0,x0,-4) -> bimm = 12'hFFE, EXTOp = 6'b000100. Then load 32'h123450B7 (lui) -> uimm = 20'h12345, EXTOp = 6'b000010.
- Load a JAL, then assert stall for 3 cycles while if_instr changes -> id_instr, id_pc and EXTOp = 6'b000001 unchanged for all 3 cycles. Deassert stall -> the new if_instr is captured next edge.
- Assert stall and flush together with a valid instruction in ID -> next cycle: id_valid = 0, id_instr = 32'h00000013, id_pc = 0, EXTOp = 0.
- Load 32'h002081B3 (add, R-type) with if_valid = 1 -> EXTOp = 0. Load any instruction with if_valid = 0 -> id_valid = 0, EXTOp = 0. Assert rst mid-stream -> all outputs at reset values on the following cycle.
